// File: rtl/m_unit.sv
// rtl/m_unit.sv - iterative RV32M multiply/divide unit for the execute stage
module m_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            valid_in,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  localparam logic [4:0]      LAST_COUNT = 5'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN    = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES   = {XLEN{1'b1}};

  state_t            state;
  logic [4:0]        count;
  logic [2:0]        func3_q;
  logic              neg_res;   // negate product / quotient at the end
  logic              neg_rem;   // remainder takes the dividend sign
  logic [2*XLEN-1:0] acc;       // {partial product high, multiplier being shifted out}
  logic [XLEN-1:0]   mcand;     // multiplicand magnitude, or divisor magnitude
  logic [XLEN-1:0]   prem;      // partial remainder (always below the divisor)
  logic [XLEN-1:0]   quo;       // dividend bits shifting out, quotient bits shifting in

  // Decode of the instruction presented in EX
  logic [2:0]      func3_in;
  logic            signed1_in;
  logic            signed2_in;
  logic            s1_in;
  logic            s2_in;
  logic [XLEN-1:0] mag1_in;
  logic [XLEN-1:0] mag2_in;
  logic            is_div_in;
  logic            div_zero_in;
  logic            div_ovf_in;
  logic [XLEN-1:0] special_res;
  logic            unused_instr_bits;

  assign func3_in   = instruction[14:12];
  assign is_div_in  = func3_in[2];
  assign signed1_in = (func3_in == F_MUL) || (func3_in == F_MULH) || (func3_in == F_MULHSU) ||
                      (func3_in == F_DIV) || (func3_in == F_REM);
  assign signed2_in = (func3_in == F_MUL) || (func3_in == F_MULH) ||
                      (func3_in == F_DIV) || (func3_in == F_REM);
  assign s1_in      = signed1_in && op1[XLEN-1];
  assign s2_in      = signed2_in && op2[XLEN-1];
  assign mag1_in    = s1_in ? (~op1 + 1'b1) : op1;
  assign mag2_in    = s2_in ? (~op2 + 1'b1) : op2;

  // Divide by zero and signed overflow resolve without iterating
  assign div_zero_in = is_div_in && (op2 == '0);
  assign div_ovf_in  = ((func3_in == F_DIV) || (func3_in == F_REM)) &&
                       (op1 == INT_MIN) && (op2 == ALL_ONES);
  assign special_res = div_zero_in ? (func3_in[1] ? op1 : ALL_ONES)
                                   : (func3_in[1] ? '0 : INT_MIN);

  assign unused_instr_bits = ^{instruction[31:15], instruction[11:0]};

  // One radix-2 step of the shift-add multiplier
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] acc_nxt;

  assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
  assign acc_nxt = {mul_sum, acc[XLEN-1:1]};

  // One radix-2 step of the restoring divider; trial is the 33-bit partial remainder
  logic [XLEN:0]   trial;
  logic [XLEN:0]   diff;
  logic            fits;
  logic [XLEN-1:0] prem_nxt;
  logic [XLEN-1:0] quo_nxt;

  assign trial    = {prem, quo[XLEN-1]};
  assign diff     = trial - {1'b0, mcand};
  assign fits     = !diff[XLEN];
  assign prem_nxt = fits ? diff[XLEN-1:0] : trial[XLEN-1:0];
  assign quo_nxt  = {quo[XLEN-2:0], fits};

  // Sign correction of the values produced by the final iteration
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;

  assign prod_fix = neg_res ? (~acc_nxt + 1'b1) : acc_nxt;
  assign quo_fix  = neg_res ? (~quo_nxt + 1'b1) : quo_nxt;
  assign rem_fix  = neg_rem ? (~prem_nxt + 1'b1) : prem_nxt;

  // Pick the result half / kind for the latched operation
  logic [XLEN-1:0] calc_res;

  always_comb begin
    calc_res = '0;
    case (func3_q)
      F_MUL:                     calc_res = prod_fix[XLEN-1:0];
      F_MULH, F_MULHSU, F_MULHU: calc_res = prod_fix[2*XLEN-1:XLEN];
      F_DIV, F_DIVU:             calc_res = quo_fix;
      F_REM, F_REMU:             calc_res = rem_fix;
      default:                   calc_res = '0;
    endcase
  end

  // Stall request: asserted on acceptance and throughout the iterations
  assign busy = !rst && !flush && (((state == IDLE) && valid_in) || (state == CALC));

  // Operation sequencer: accept, iterate, present the result for one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      func3_q <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      acc     <= '0;
      mcand   <= '0;
      prem    <= '0;
      quo     <= '0;
      done    <= 1'b0;
      result  <= '0;
      rd_out  <= '0;
    end else if (flush) begin
      state <= IDLE;
      count <= '0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (valid_in) begin
            func3_q <= func3_in;
            rd_out  <= rd_in;
            neg_res <= s1_in ^ s2_in;
            neg_rem <= s1_in;
            count   <= '0;
            if (div_zero_in || div_ovf_in) begin
              result <= special_res;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              acc   <= {{XLEN{1'b0}}, mag2_in};
              mcand <= is_div_in ? mag2_in : mag1_in;
              prem  <= '0;
              quo   <= mag1_in;
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc   <= acc_nxt;
          prem  <= prem_nxt;
          quo   <= quo_nxt;
          count <= count + 5'd1;
          if (count == LAST_COUNT) begin
            result <= calc_res;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m_unit.sv
// tb/tb_m_unit.sv - randomized self-checking bench for m_unit against an arithmetic model
module tb_m_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        valid_in;
  logic [31:0] instruction;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] last_res;

  always #5 clk = ~clk;

  m_unit #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .valid_in    (valid_in),
    .instruction (instruction),
    .op1         (op1),
    .op2         (op2),
    .rd_in       (rd_in),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .rd_out      (rd_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [2:0] f3, input logic [4:0] rd);
    return {7'b0000001, 5'd2, 5'd1, f3, rd, 7'b0110011};
  endfunction

  // Reference: plain 64-bit signed/unsigned arithmetic (C-style truncating division)
  function automatic logic [31:0] model_res(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ua;
    longint      ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFFFFFF; p = ua / ub; return p[31:0]; end
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  function automatic bit model_short(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    return f3[2] && ((b == 0) || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  // One full operation starting at the next cycle; ends inside the done cycle
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit fl_done);
    logic [31:0] exp;
    int          lat;
    exp = model_res(f3, a, b);
    lat = model_short(f3, a, b) ? 1 : 33;
    @(posedge clk); #1;
    flush = 1'b0; valid_in = 1'b1;
    instruction = mk_instr(f3, rd); op1 = a; op2 = b; rd_in = rd;
    #1;
    chk("busy_accept", 32'(busy), 1);
    chk("done_accept", 32'(done), 0);
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      if (k == lat && fl_done) flush = 1'b1;
      #1;
      if (k < lat) begin
        chk("busy_calc", 32'(busy), 1);
        chk("done_calc", 32'(done), 0);
        if (k == 16) chk("result_hold", result, last_res);
      end else begin
        chk("done_pulse", 32'(done), 1);
        chk("busy_done", 32'(busy), 0);
        chk("result", result, exp);
        chk("rd_out", 32'(rd_out), 32'(rd));
      end
    end
    last_res = exp;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      valid_in = 1'b0; flush = 1'b0;
      #1;
      chk("busy_idle", 32'(busy), 0);
      chk("done_idle", 32'(done), 0);
      chk("result_idle", result, last_res);
    end
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; valid_in = 1'b1;
    instruction = mk_instr(3'd0, 5'd3); op1 = 32'd5; op2 = 32'd6; rd_in = 5'd3;
    last_res = '0;

    // reset state, with a request pending while rst is high
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_result", result, 0);
    chk("rst_rd", 32'(rd_out), 0);
    @(posedge clk); #1;
    rst = 1'b0; valid_in = 1'b0;
    #1;
    chk("post_rst_busy", 32'(busy), 0);
    idle(1);

    // directed operations
    run_op(3'd0, 32'd7, 32'hFFFFFFFD, 5'd5, 0);
    idle(1);
    run_op(3'd1, 32'h80000000, 32'h80000000, 5'd6, 0);
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 0);
    run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8, 0);
    run_op(3'd4, 32'hFFFFFFF9, 32'd2, 5'd9, 0);
    run_op(3'd6, 32'hFFFFFFF9, 32'd2, 5'd10, 0);
    run_op(3'd5, 32'd100, 32'd7, 5'd11, 0);
    run_op(3'd7, 32'd100, 32'd7, 5'd12, 0);
    run_op(3'd5, 32'd100, 32'd0, 5'd13, 0);
    run_op(3'd6, 32'd100, 32'd0, 5'd14, 0);
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd15, 0);
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd16, 0);
    idle(2);

    // flush mid multiply, then a divide accepted two cycles later
    @(posedge clk); #1;
    valid_in = 1'b1; instruction = mk_instr(3'd0, 5'd17);
    op1 = 32'd1234; op2 = 32'd5678; rd_in = 5'd17;
    #1;
    chk("fl_busy_accept", 32'(busy), 1);
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
      flush = (k == 10);
      if (k == 11) valid_in = 1'b0;
      #1;
      if (k < 10) chk("fl_busy_calc", 32'(busy), 1);
      else        chk("fl_busy_killed", 32'(busy), 0);
      chk("fl_done", 32'(done), 0);
      chk("fl_result", result, last_res);
    end
    run_op(3'd5, 32'd9, 32'd3, 5'd18, 0);
    idle(1);

    // flush together with valid_in in IDLE is not an acceptance
    @(posedge clk); #1;
    valid_in = 1'b1; flush = 1'b1; instruction = mk_instr(3'd4, 5'd19);
    op1 = 32'd50; op2 = 32'd0; rd_in = 5'd19;
    #1;
    chk("fv_busy", 32'(busy), 0);
    idle(3);

    // flush during the done cycle still shows done
    run_op(3'd3, 32'hDEADBEEF, 32'h12345678, 5'd20, 1);
    idle(1);

    // reset in the middle of a divide
    @(posedge clk); #1;
    valid_in = 1'b1; instruction = mk_instr(3'd4, 5'd21);
    op1 = 32'd1000; op2 = 32'd3; rd_in = 5'd21;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      if (k == 5) rst = 1'b1;
      #1;
      chk(k < 5 ? "rst_mid_busy_calc" : "rst_mid_busy", 32'(busy), k < 5 ? 1 : 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; valid_in = 1'b0;
    #1;
    chk("rst_mid_done", 32'(done), 0);
    chk("rst_mid_result", result, 0);
    chk("rst_mid_rd", 32'(rd_out), 0);
    last_res = '0;
    idle(2);

    // back to back: MUL then MULHU with no gap
    run_op(3'd0, 32'h0001_0003, 32'hFFFF_0005, 5'd22, 0);
    run_op(3'd3, 32'h8765_4321, 32'hFEDC_BA98, 5'd23, 0);
    idle(1);

    // randomized operations, operand corners and gaps of 0..2 cycles
    for (int i = 0; i < 60; i++) begin
      run_op(3'($urandom_range(0, 7)), rand_opnd(), rand_opnd(),
             5'($urandom_range(0, 31)), ($urandom_range(0, 7) == 0));
      idle($urandom_range(0, 2));
    end
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
